// File: rtl/core_seq_if.sv
// ----------------------------------------------------------------------------
// core_seq_if
// Bundle between the engine start controller (master) and one core's block
// sequencer (slave).
//
//   start        master -> slave  single-cycle start pulse
//   busy         slave -> master  high in every load or round cycle
//   cur_thread   slave -> master  thread of the block in progress
//   load_en      slave -> master  high in load cycles
//   load_idx     slave -> master  load word index, 0 when not loading
//   round_en     slave -> master  high in round cycles
//   round        slave -> master  round index / K-ROM address, 0 otherwise
//   done         slave -> master  one-cycle completion pulse
//   done_thread  slave -> master  thread of the completed block
//   err          slave -> master  sticky protocol-violation flag
// ----------------------------------------------------------------------------
interface core_seq_if #(
  parameter int N_LOAD   = 8,
  parameter int N_ROUNDS = 64
);

  localparam int IDX_W = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;
  localparam int RND_W = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;

  logic             start;
  logic             busy;
  logic             cur_thread;
  logic             load_en;
  logic [IDX_W-1:0] load_idx;
  logic             round_en;
  logic [RND_W-1:0] round;
  logic             done;
  logic             done_thread;
  logic             err;

  modport master (
    output start,
    input  busy, cur_thread, load_en, load_idx, round_en, round,
           done, done_thread, err
  );

  modport slave (
    input  start,
    output busy, cur_thread, load_en, load_idx, round_en, round,
           done, done_thread, err
  );

endinterface

// File: rtl/core_seq.sv
// ----------------------------------------------------------------------------
// core_seq
// Core-side block sequencer. Each accepted start pulse runs one SHA-256 block
// schedule for one of the core's two interleaved threads: N_LOAD load cycles
// followed by N_ROUNDS round cycles, then a done pulse tagged with the thread.
// A start is only legal while idle or in the last round cycle; any other start
// is ignored and raises a sticky err flag.
//
// Ports:
//   CLK    clock
//   reset  asynchronous active-high reset
//   bus    core_seq_if slave modport (start in; schedule, done, err out)
//
// Parameters:
//   N_LOAD    load cycles per block
//   N_ROUNDS  round cycles per block
//   CORE_ID   core number, only used to tag assertion messages
// ----------------------------------------------------------------------------
module core_seq #(
  parameter int N_LOAD   = 8,
  parameter int N_ROUNDS = 64,
  parameter int CORE_ID  = 0
) (
  input  logic        CLK,
  input  logic        reset,
  core_seq_if.slave   bus
);

  localparam int IDX_W = (N_LOAD > 1) ? $clog2(N_LOAD) : 1;
  localparam int RND_W = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;
  // One shared counter serves both phases, so it is sized for the longer one.
  localparam int CNT_W = (IDX_W > RND_W) ? IDX_W : RND_W;

  localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(N_LOAD - 1);
  localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(N_ROUNDS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    ROUNDS = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             next_thread;
  logic             next_thread_nxt;

  logic             last_load;
  logic             last_round;
  logic             accept;
  logic             violation;

  // Registered output copies, plus their next-cycle values.
  logic             busy_q,        busy_d;
  logic             cur_thread_q,  cur_thread_d;
  logic             load_en_q,     load_en_d;
  logic [IDX_W-1:0] load_idx_q,    load_idx_d;
  logic             round_en_q,    round_en_d;
  logic [RND_W-1:0] round_q,       round_d;
  logic             done_q,        done_d;
  logic             done_thread_q, done_thread_d;
  logic             err_q,         err_d;

  // Terminal counts force the phase change; the counter never wraps in place.
  assign last_load  = (state == LOAD)   && (cnt == LOAD_LAST);
  assign last_round = (state == ROUNDS) && (cnt == ROUND_LAST);

  // The last round cycle accepts a start so back-to-back blocks have no gap.
  assign accept    = bus.start && ((state == IDLE) || last_round);
  assign violation = bus.start && !accept;

  // State register: phase, shared counter and the thread the next block gets.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      next_thread <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      next_thread <= next_thread_nxt;
    end
  end

  // Next-state logic: IDLE -> LOAD -> ROUNDS -> (LOAD | IDLE).
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    next_thread_nxt = next_thread ^ accept;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
        end
      end
      LOAD: begin
        if (last_load) begin
          state_nxt = ROUNDS;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      ROUNDS: begin
        if (last_round) begin
          state_nxt = accept ? LOAD : IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode. Outputs are decoded from the upcoming state and then
  // registered, so every output reflects the state it is registered next to.
  // done fires the cycle after the last round, tagged with the thread still
  // held in cur_thread_q, even when a new block already takes over cur_thread.
  always_comb begin
    busy_d        = (state_nxt != IDLE);
    load_en_d     = (state_nxt == LOAD);
    round_en_d    = (state_nxt == ROUNDS);
    load_idx_d    = '0;
    round_d       = '0;
    if (state_nxt == LOAD) begin
      load_idx_d = cnt_nxt[IDX_W-1:0];
    end
    if (state_nxt == ROUNDS) begin
      round_d = cnt_nxt[RND_W-1:0];
    end
    cur_thread_d  = accept ? next_thread : cur_thread_q;
    done_d        = last_round;
    done_thread_d = last_round ? cur_thread_q : 1'b0;
    err_d         = err_q | violation;
  end

  // Output registers.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      busy_q        <= 1'b0;
      cur_thread_q  <= 1'b0;
      load_en_q     <= 1'b0;
      load_idx_q    <= '0;
      round_en_q    <= 1'b0;
      round_q       <= '0;
      done_q        <= 1'b0;
      done_thread_q <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      cur_thread_q  <= cur_thread_d;
      load_en_q     <= load_en_d;
      load_idx_q    <= load_idx_d;
      round_en_q    <= round_en_d;
      round_q       <= round_d;
      done_q        <= done_d;
      done_thread_q <= done_thread_d;
      err_q         <= err_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.cur_thread  = cur_thread_q;
  assign bus.load_en     = load_en_q;
  assign bus.load_idx    = load_idx_q;
  assign bus.round_en    = round_en_q;
  assign bus.round       = round_q;
  assign bus.done        = done_q;
  assign bus.done_thread = done_thread_q;
  assign bus.err         = err_q;

  // Load and round phases are mutually exclusive and both imply busy.
  a_phase_exclusive : assert property (
    @(posedge CLK) disable iff (reset)
      !(load_en_q && round_en_q) && ((load_en_q || round_en_q) == busy_q)
  ) else $error("core_seq %0d: inconsistent phase outputs", CORE_ID);

  // err only clears on reset.
  a_err_sticky : assert property (
    @(posedge CLK) disable iff (reset) err_q |=> err_q
  ) else $error("core_seq %0d: err dropped without reset", CORE_ID);

endmodule

// File: tb/tb_core_seq.sv
// ----------------------------------------------------------------------------
// tb_core_seq
// Self-checking bench for core_seq: a constant vector table for the directed
// timeline, a hand-written asynchronous-reset sequence, and random / legal
// controller-like stimulus compared against a block-level reference model.
// ----------------------------------------------------------------------------
module tb_core_seq;

  localparam int NL = 8;
  localparam int NR = 64;
  localparam int BLK = NL + NR;

  logic CLK = 1'b0;
  logic reset;

  always #5 CLK = ~CLK;

  core_seq_if #(.N_LOAD(NL), .N_ROUNDS(NR)) bus ();

  core_seq #(.N_LOAD(NL), .N_ROUNDS(NR), .CORE_ID(0)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       busy;
    logic       cur_thread;
    logic       load_en;
    logic [2:0] load_idx;
    logic       round_en;
    logic [5:0] round;
    logic       done;
    logic       done_thread;
    logic       err;
  } out_t;

  typedef struct {
    int   cyc;
    logic start;
    out_t exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: remembers the last two accepted starts as absolute cycles.
  int   m_last, m_prev;
  logic m_last_thr, m_prev_thr, m_nthr, m_err;

  function automatic out_t mk(logic b, logic ct, logic le, int li, logic re,
                              int rd, logic dn, logic dt, logic er);
    out_t v;
    v.busy = b; v.cur_thread = ct; v.load_en = le; v.load_idx = 3'(li);
    v.round_en = re; v.round = 6'(rd); v.done = dn; v.done_thread = dt;
    v.err = er;
    return v;
  endfunction

  function automatic out_t sample();
    return mk(bus.busy, bus.cur_thread, bus.load_en, int'(bus.load_idx),
              bus.round_en, int'(bus.round), bus.done, bus.done_thread, bus.err);
  endfunction

  function automatic string fmt(out_t v);
    return $sformatf("busy=%0b cur=%0b le=%0b li=%0d re=%0b rd=%0d done=%0b dt=%0b err=%0b",
                     v.busy, v.cur_thread, v.load_en, v.load_idx, v.round_en,
                     v.round, v.done, v.done_thread, v.err);
  endfunction

  task automatic check_output(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s cyc=%0d got {%s} required {%s}",
                  name, cyc, fmt(act), fmt(exp));
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("[TB] FAIL %s cyc=%0d got %0d required %0d", name, cyc, act, exp);
  endtask

  // Drives start for the current cycle and returns the outputs seen in it.
  task automatic apply_stimulus(input logic s, output out_t o);
    bus.start = s;
    @(negedge CLK);
    o = sample();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    m_last = -1000; m_prev = -1000;
    m_last_thr = 1'b0; m_prev_thr = 1'b0; m_nthr = 1'b0; m_err = 1'b0;
  endtask

  // Expected outputs in cycle c, from block start offsets.
  function automatic out_t model_expect(int c);
    int   off;
    out_t e;
    off = c - m_last;
    e = mk(0, m_last_thr, 0, 0, 0, 0, 0, 0, m_err);
    if (off >= 1 && off <= BLK) e.busy = 1'b1;
    if (off >= 1 && off <= NL) begin
      e.load_en = 1'b1; e.load_idx = 3'(off - 1);
    end
    if (off > NL && off <= BLK) begin
      e.round_en = 1'b1; e.round = 6'(off - NL - 1);
    end
    if (off == BLK + 1) begin
      e.done = 1'b1; e.done_thread = m_last_thr;
    end else if (c - m_prev == BLK + 1) begin
      e.done = 1'b1; e.done_thread = m_prev_thr;
    end
    return e;
  endfunction

  task automatic model_update(input int c, input logic s);
    int off;
    off = c - m_last;
    if (s) begin
      if (off < 1 || off >= BLK) begin
        m_prev = m_last; m_prev_thr = m_last_thr;
        m_last = c; m_last_thr = m_nthr;
        m_nthr = ~m_nthr;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    bus.start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    reset = 1'b0;
    cyc = 0;
    model_reset();
  endtask

  // Watchdog so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t tbl[$];
    out_t o;
    out_t zero;
    int   idx;
    int   c;
    int   next_at;
    int   n_done;
    int   n_starts;
    int   inflight;
    logic s;
    logic err_any;

    zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Directed timeline: back-to-back at 10/82/154, late start at 227,
    // illegal start at 260 during the last block.
    //                cyc  st    b  ct le li re rd  dn dt er
    tbl.push_back('{  0, 1'b0, mk(0, 0, 0, 0, 0, 0,  0, 0, 0)});
    tbl.push_back('{ 10, 1'b1, mk(0, 0, 0, 0, 0, 0,  0, 0, 0)});
    tbl.push_back('{ 11, 1'b0, mk(1, 0, 1, 0, 0, 0,  0, 0, 0)});
    tbl.push_back('{ 14, 1'b0, mk(1, 0, 1, 3, 0, 0,  0, 0, 0)});
    tbl.push_back('{ 18, 1'b0, mk(1, 0, 1, 7, 0, 0,  0, 0, 0)});
    tbl.push_back('{ 19, 1'b0, mk(1, 0, 0, 0, 1, 0,  0, 0, 0)});
    tbl.push_back('{ 50, 1'b0, mk(1, 0, 0, 0, 1, 31, 0, 0, 0)});
    tbl.push_back('{ 82, 1'b1, mk(1, 0, 0, 0, 1, 63, 0, 0, 0)});
    tbl.push_back('{ 83, 1'b0, mk(1, 1, 1, 0, 0, 0,  1, 0, 0)});
    tbl.push_back('{ 91, 1'b0, mk(1, 1, 0, 0, 1, 0,  0, 0, 0)});
    tbl.push_back('{154, 1'b1, mk(1, 1, 0, 0, 1, 63, 0, 0, 0)});
    tbl.push_back('{155, 1'b0, mk(1, 0, 1, 0, 0, 0,  1, 1, 0)});
    tbl.push_back('{226, 1'b0, mk(1, 0, 0, 0, 1, 63, 0, 0, 0)});
    tbl.push_back('{227, 1'b1, mk(0, 0, 0, 0, 0, 0,  1, 0, 0)});
    tbl.push_back('{228, 1'b0, mk(1, 1, 1, 0, 0, 0,  0, 0, 0)});
    tbl.push_back('{236, 1'b0, mk(1, 1, 0, 0, 1, 0,  0, 0, 0)});
    tbl.push_back('{259, 1'b0, mk(1, 1, 0, 0, 1, 23, 0, 0, 0)});
    tbl.push_back('{260, 1'b1, mk(1, 1, 0, 0, 1, 24, 0, 0, 0)});
    tbl.push_back('{261, 1'b0, mk(1, 1, 0, 0, 1, 25, 0, 0, 1)});
    tbl.push_back('{299, 1'b0, mk(1, 1, 0, 0, 1, 63, 0, 0, 1)});
    tbl.push_back('{300, 1'b0, mk(0, 1, 0, 0, 0, 0,  1, 1, 1)});
    tbl.push_back('{301, 1'b0, mk(0, 1, 0, 0, 0, 0,  0, 0, 1)});

    bus.start = 1'b0;
    reset = 1'b1;
    #12;
    check_output("reset_state", sample(), zero);

    // ---------------- table-driven timeline ----------------
    do_reset();
    idx = 0;
    for (int i = 0; i <= 301; i++) begin
      s = 1'b0;
      if (idx < tbl.size() && tbl[idx].cyc == cyc) s = tbl[idx].start;
      c = cyc;
      apply_stimulus(s, o);
      if (idx < tbl.size() && tbl[idx].cyc == c) begin
        check_output($sformatf("vec%0d", tbl[idx].cyc), o, tbl[idx].exp);
        idx++;
      end
      if (c >= 11 && c <= 226) check_val("busy_run", int'(o.busy), 1);
    end

    // ---------------- asynchronous reset mid-block ----------------
    do_reset();
    for (int i = 0; i < 50; i++) begin
      c = cyc;
      apply_stimulus(c == 10 || c == 30, o);
      if (c == 31) check_output("rst_pre_err", o, mk(1, 0, 0, 0, 1, 12, 0, 0, 1));
    end
    bus.start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check_output("rst_async", sample(), zero);
    @(posedge CLK);
    #1;
    cyc++;
    reset = 1'b0;
    for (int i = 0; i < 90; i++) begin
      c = cyc;
      apply_stimulus(c == 60, o);
      if (c == 59)  check_output("rst_idle",  o, zero);
      if (c == 61)  check_output("rst_load0", o, mk(1, 0, 1, 0, 0, 0, 0, 0, 0));
      if (c == 83)  check_output("rst_nodone", o, mk(1, 0, 0, 0, 1, 14, 0, 0, 0));
      if (c == 132) check_output("rst_last",  o, mk(1, 0, 0, 0, 1, 63, 0, 0, 0));
      if (c == 133) check_output("rst_done",  o, mk(0, 0, 0, 0, 0, 0, 1, 0, 0));
    end

    // ---------------- random stimulus vs model ----------------
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      c = cyc;
      s = ($urandom_range(0, 39) == 0);
      if (c - m_last == BLK && $urandom_range(0, 1) == 1) s = 1'b1;
      apply_stimulus(s, o);
      check_output("rand", o, model_expect(c));
      model_update(c, s);
    end

    // ---------------- legal controller-like pacing ----------------
    do_reset();
    next_at = 5;
    n_done = 0;
    n_starts = 0;
    err_any = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      c = cyc;
      s = (c == next_at);
      if (s) begin
        n_starts++;
        next_at = c + BLK + int'($urandom_range(0, 3));
      end
      apply_stimulus(s, o);
      check_output("legal", o, model_expect(c));
      model_update(c, s);
      if (o.done) n_done++;
      err_any = err_any | o.err;
    end
    inflight = 0;
    if (m_last >= 0 && m_last + BLK + 1 > cyc - 1) inflight++;
    if (m_prev >= 0 && m_prev + BLK + 1 > cyc - 1) inflight++;
    check_val("legal_err", int'(err_any), 0);
    check_val("legal_done_count", n_done, n_starts - inflight);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
